// File: rtl/arch_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : arch_pkg
//  Description : Shared architectural constants and types for the register
//                file / operand fetch slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package arch_pkg;

   localparam int DATA_W   = 32;          // operand / result width
   localparam int REG_AW   = 4;           // register address width
   localparam int NUM_REGS = 2 ** REG_AW; // architectural registers
   localparam int OP_W     = 6;           // opaque decoded-operation width

   typedef logic [REG_AW-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] word_t;

endpackage : arch_pkg
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : reg_scoreboard
//  Description : Busy-bit scoreboard for in-flight destination registers.
//                Produces the decode hazard (RAW on either source, WAW on
//                the destination), taking a same-cycle writeback into account.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                i_set_en/_rd    - mark a register busy (accepted writer)
//                i_fclr_en/_rd   - clear a register (flushed writer)
//                i_wb_en/_rd     - clear a register (writeback this cycle)
//                i_rs1/i_use1    - source 1 lookup
//                i_rs2/i_use2    - source 2 lookup
//                i_rd/i_wr       - destination lookup
//                o_hazard        - instruction must not issue this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
   parameter int REG_AW = arch_pkg::REG_AW
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_set_en,
   input  logic [REG_AW-1:0] i_set_rd,
   input  logic              i_fclr_en,
   input  logic [REG_AW-1:0] i_fclr_rd,
   input  logic              i_wb_en,
   input  logic [REG_AW-1:0] i_wb_rd,
   input  logic [REG_AW-1:0] i_rs1,
   input  logic              i_use1,
   input  logic [REG_AW-1:0] i_rs2,
   input  logic              i_use2,
   input  logic [REG_AW-1:0] i_rd,
   input  logic              i_wr,
   output logic              o_hazard
);

   localparam int NUM_REGS = 2 ** REG_AW;
   localparam logic [NUM_REGS-1:0] c_ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

   logic [NUM_REGS-1:0] r_busy;
   logic [NUM_REGS-1:0] w_set_mask;
   logic [NUM_REGS-1:0] w_fclr_mask;
   logic [NUM_REGS-1:0] w_wb_mask;
   logic [NUM_REGS-1:0] w_busy_nxt;
   logic                w_haz1;
   logic                w_haz2;
   logic                w_hazd;

   assign w_set_mask  = i_set_en  ? (c_ONE << i_set_rd)  : '0;
   assign w_fclr_mask = i_fclr_en ? (c_ONE << i_fclr_rd) : '0;
   assign w_wb_mask   = i_wb_en   ? (c_ONE << i_wb_rd)   : '0;

   // Both clear sources drop the bit; the set is OR-ed last so a new writer
   // claiming the register wins over any same-cycle clear.
   assign w_busy_nxt = (r_busy & ~w_fclr_mask & ~w_wb_mask) | w_set_mask;

   // A register being written back this cycle is no longer a hazard: the
   // value is forwarded and the busy bit is released at the same edge.
   assign w_haz1 = i_use1 && r_busy[i_rs1] && !(i_wb_en && (i_wb_rd == i_rs1));
   assign w_haz2 = i_use2 && r_busy[i_rs2] && !(i_wb_en && (i_wb_rd == i_rs2));
   assign w_hazd = i_wr   && r_busy[i_rd]  && !(i_wb_en && (i_wb_rd == i_rd));

   assign o_hazard = w_haz1 | w_haz2 | w_hazd;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

endmodule : reg_scoreboard
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : operand_fetch
//  Description : Issue stage following the register file. Drives RF read
//                addresses, forwards a same-cycle writeback, stalls decode on
//                RAW/WAW hazards and registers operands for execute.
//  Ports       : clk, reset              - clock, synchronous active-high reset
//                dec_*                   - decoded instruction (valid/ready)
//                Rs1, Rs2, Bus_A, Bus_B  - RF read addresses / data
//                wb_we, wb_rd, wb_data   - RF writeback snoop
//                flush                   - discard the output register
//                ex_*                    - operands to execute (valid/ready)
//                stall_cnt               - saturating decode-stall counter
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch #(
   parameter int DATA_W = arch_pkg::DATA_W,
   parameter int REG_AW = arch_pkg::REG_AW,
   parameter int OP_W   = arch_pkg::OP_W,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   // decode side
   input  logic              dec_valid,
   output logic              dec_ready,
   input  logic [REG_AW-1:0] dec_rs1,
   input  logic              dec_use1,
   input  logic [REG_AW-1:0] dec_rs2,
   input  logic              dec_use2,
   input  logic [REG_AW-1:0] dec_rd,
   input  logic              dec_wr,
   input  logic [OP_W-1:0]   dec_op,
   // register file
   output logic [REG_AW-1:0] Rs1,
   output logic [REG_AW-1:0] Rs2,
   input  logic [DATA_W-1:0] Bus_A,
   input  logic [DATA_W-1:0] Bus_B,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   // control
   input  logic              flush,
   // execute side
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   output logic [REG_AW-1:0] ex_rd,
   output logic              ex_wr,
   output logic [OP_W-1:0]   ex_op,
   // performance
   output logic [CNT_W-1:0]  stall_cnt
);

   logic              r_ex_valid;
   logic [DATA_W-1:0] r_ex_a;
   logic [DATA_W-1:0] r_ex_b;
   logic [REG_AW-1:0] r_ex_rd;
   logic              r_ex_wr;
   logic [OP_W-1:0]   r_ex_op;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic              w_hit_a;
   logic              w_hit_b;
   logic [DATA_W-1:0] w_opnd_a;
   logic [DATA_W-1:0] w_opnd_b;
   logic              w_hazard;
   logic              w_dec_ready;
   logic              w_accept;
   logic              w_flush_clr;

   // RF reads are combinational, so the addresses are just the decode fields.
   assign Rs1 = dec_rs1;
   assign Rs2 = dec_rs2;

   // The RF only shows a write on its read port after the edge, so a
   // same-cycle writeback must be forwarded here.
   assign w_hit_a  = wb_we && (wb_rd == dec_rs1);
   assign w_hit_b  = wb_we && (wb_rd == dec_rs2);
   assign w_opnd_a = w_hit_a ? wb_data : Bus_A;
   assign w_opnd_b = w_hit_b ? wb_data : Bus_B;

   assign w_dec_ready = !w_hazard && (!r_ex_valid || ex_ready) && !flush;
   assign w_accept    = dec_valid && w_dec_ready;

   // A flushed writer never reaches writeback, so its busy bit is released here.
   assign w_flush_clr = flush && r_ex_valid && r_ex_wr;

   reg_scoreboard #(
      .REG_AW (REG_AW)
   ) u_scoreboard (
      .clk       (clk),
      .reset     (reset),
      .i_set_en  (w_accept && dec_wr),
      .i_set_rd  (dec_rd),
      .i_fclr_en (w_flush_clr),
      .i_fclr_rd (r_ex_rd),
      .i_wb_en   (wb_we),
      .i_wb_rd   (wb_rd),
      .i_rs1     (dec_rs1),
      .i_use1    (dec_use1),
      .i_rs2     (dec_rs2),
      .i_use2    (dec_use2),
      .i_rd      (dec_rd),
      .i_wr      (dec_wr),
      .o_hazard  (w_hazard)
   );

   // Output pipeline register: payload only changes on accept so it stays
   // stable while execute applies backpressure.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ex_valid <= 1'b0;
         r_ex_a     <= '0;
         r_ex_b     <= '0;
         r_ex_rd    <= '0;
         r_ex_wr    <= 1'b0;
         r_ex_op    <= '0;
      end else if (w_accept) begin
         r_ex_valid <= 1'b1;
         r_ex_a     <= w_opnd_a;
         r_ex_b     <= w_opnd_b;
         r_ex_rd    <= dec_rd;
         r_ex_wr    <= dec_wr;
         r_ex_op    <= dec_op;
      end else if (ex_ready || flush) begin
         r_ex_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= '0;
      end else if (dec_valid && !w_dec_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign dec_ready = w_dec_ready;
   assign ex_valid  = r_ex_valid;
   assign ex_a      = r_ex_a;
   assign ex_b      = r_ex_b;
   assign ex_rd     = r_ex_rd;
   assign ex_wr     = r_ex_wr;
   assign ex_op     = r_ex_op;
   assign stall_cnt = r_stall_cnt;

endmodule : operand_fetch
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_fetch
//  Description : Self-checking bench for operand_fetch. Directed scenarios
//                followed by randomized traffic, all compared against a
//                behavioural model of the issue stage and register file.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

   localparam int DW      = 32;
   localparam int AW      = 4;
   localparam int OW      = 6;
   localparam int TB_CNTW = 5;
   localparam int CNT_MAX = (1 << TB_CNTW) - 1;

   logic            clk;
   logic            reset;
   logic            dec_valid;
   logic            dec_ready;
   logic [AW-1:0]   dec_rs1;
   logic            dec_use1;
   logic [AW-1:0]   dec_rs2;
   logic            dec_use2;
   logic [AW-1:0]   dec_rd;
   logic            dec_wr;
   logic [OW-1:0]   dec_op;
   logic [AW-1:0]   Rs1;
   logic [AW-1:0]   Rs2;
   logic [DW-1:0]   Bus_A;
   logic [DW-1:0]   Bus_B;
   logic            wb_we;
   logic [AW-1:0]   wb_rd;
   logic [DW-1:0]   wb_data;
   logic            flush;
   logic            ex_valid;
   logic            ex_ready;
   logic [DW-1:0]   ex_a;
   logic [DW-1:0]   ex_b;
   logic [AW-1:0]   ex_rd;
   logic            ex_wr;
   logic [OW-1:0]   ex_op;
   logic [TB_CNTW-1:0] stall_cnt;

   // register file model, read combinationally through the DUT's addresses
   logic [DW-1:0] rf [16];
   assign Bus_A = rf[Rs1];
   assign Bus_B = rf[Rs2];

   // behavioural model state
   bit            m_busy [16];
   logic          m_exv;
   logic [DW-1:0] m_exa;
   logic [DW-1:0] m_exb;
   logic [AW-1:0] m_exrd;
   logic          m_exwr;
   logic [OW-1:0] m_exop;
   int            m_cnt;

   int n_checks;
   int n_errors;

   operand_fetch #(
      .DATA_W (DW),
      .REG_AW (AW),
      .OP_W   (OW),
      .CNT_W  (TB_CNTW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .dec_valid (dec_valid),
      .dec_ready (dec_ready),
      .dec_rs1   (dec_rs1),
      .dec_use1  (dec_use1),
      .dec_rs2   (dec_rs2),
      .dec_use2  (dec_use2),
      .dec_rd    (dec_rd),
      .dec_wr    (dec_wr),
      .dec_op    (dec_op),
      .Rs1       (Rs1),
      .Rs2       (Rs2),
      .Bus_A     (Bus_A),
      .Bus_B     (Bus_B),
      .wb_we     (wb_we),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .flush     (flush),
      .ex_valid  (ex_valid),
      .ex_ready  (ex_ready),
      .ex_a      (ex_a),
      .ex_b      (ex_b),
      .ex_rd     (ex_rd),
      .ex_wr     (ex_wr),
      .ex_op     (ex_op),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      dec_valid = 1'b0; dec_rs1 = '0; dec_use1 = 1'b0; dec_rs2 = '0; dec_use2 = 1'b0;
      dec_rd = '0; dec_wr = 1'b0; dec_op = '0;
      wb_we = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0;
   endtask

   task automatic issue(input logic [AW-1:0] rs1, input logic u1, input logic [AW-1:0] rs2,
                        input logic u2, input logic [AW-1:0] rd, input logic wr, input logic [OW-1:0] op);
      dec_valid = 1'b1; dec_rs1 = rs1; dec_use1 = u1; dec_rs2 = rs2; dec_use2 = u2;
      dec_rd = rd; dec_wr = wr; dec_op = op;
   endtask

   // One clock: check the combinational handshake, advance the model by the
   // behavioural rules, then check the registered outputs after the edge.
   task automatic step();
      logic          fwd1, fwd2, fwdd, haz, exp_rdy, acc, fclr;
      logic [DW-1:0] a, b;
      #1;
      fwd1 = wb_we && (wb_rd == dec_rs1);
      fwd2 = wb_we && (wb_rd == dec_rs2);
      fwdd = wb_we && (wb_rd == dec_rd);
      haz  = (dec_use1 && m_busy[dec_rs1] && !fwd1) ||
             (dec_use2 && m_busy[dec_rs2] && !fwd2) ||
             (dec_wr   && m_busy[dec_rd]  && !fwdd);
      exp_rdy = !haz && (!m_exv || ex_ready) && !flush;
      acc     = dec_valid && exp_rdy;
      fclr    = flush && m_exv && m_exwr;
      a = fwd1 ? wb_data : rf[dec_rs1];
      b = fwd2 ? wb_data : rf[dec_rs2];
      chk("dec_ready", 64'(dec_ready), 64'(exp_rdy));
      chk("Rs1", 64'(Rs1), 64'(dec_rs1));
      chk("Rs2", 64'(Rs2), 64'(dec_rs2));
      @(posedge clk);
      #1;
      if (reset) begin
         foreach (m_busy[r]) m_busy[r] = 1'b0;
         m_exv = 1'b0; m_exa = '0; m_exb = '0; m_exrd = '0; m_exwr = 1'b0; m_exop = '0;
         m_cnt = 0;
      end else begin
         for (int r = 0; r < 16; r++) begin
            if (fclr && (m_exrd == 4'(r)))  m_busy[r] = 1'b0;
            if (wb_we && (wb_rd == 4'(r)))   m_busy[r] = 1'b0;
            if (acc && dec_wr && (dec_rd == 4'(r))) m_busy[r] = 1'b1;
         end
         if (dec_valid && !exp_rdy && (m_cnt < CNT_MAX)) m_cnt++;
         if (acc) begin
            m_exv = 1'b1; m_exa = a; m_exb = b; m_exrd = dec_rd; m_exwr = dec_wr; m_exop = dec_op;
         end else if (ex_ready || flush) begin
            m_exv = 1'b0;
         end
      end
      if (wb_we) rf[wb_rd] = wb_data;
      chk("ex_valid", 64'(ex_valid), 64'(m_exv));
      chk("ex_a", 64'(ex_a), 64'(m_exa));
      chk("ex_b", 64'(ex_b), 64'(m_exb));
      chk("ex_rd", 64'(ex_rd), 64'(m_exrd));
      chk("ex_wr", 64'(ex_wr), 64'(m_exwr));
      chk("ex_op", 64'(ex_op), 64'(m_exop));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      for (int r = 0; r < 16; r++) rf[r] = $urandom;
      foreach (m_busy[r]) m_busy[r] = 1'b0;
      m_exv = 1'b0; m_exa = '0; m_exb = '0; m_exrd = '0; m_exwr = 1'b0; m_exop = '0; m_cnt = 0;
      idle();
      ex_ready = 1'b1;
      reset    = 1'b1;
      @(posedge clk);
      #1;
      step();
      chk("reset_ex_valid", 64'(ex_valid), 64'd0);
      chk("reset_ex_a", 64'(ex_a), 64'd0);
      chk("reset_stall_cnt", 64'(stall_cnt), 64'd0);
      reset = 1'b0;

      // basic issue with RF operands
      rf[1] = 32'h1234_5678;
      rf[2] = 32'hCAFE_F00D;
      issue(4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 6'h2A);
      step();
      chk("t1_ex_valid", 64'(ex_valid), 64'd1);
      chk("t1_ex_a", 64'(ex_a), 64'h1234_5678);
      chk("t1_ex_b", 64'(ex_b), 64'hCAFE_F00D);

      // RAW on R3: stall, then forward the writeback
      issue(4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 6'h11);
      step();
      step();
      chk("t2_stall_cnt", 64'(stall_cnt), 64'd2);
      wb_we = 1'b1; wb_rd = 4'd3; wb_data = 32'hA5A5_A5A5;
      step();
      wb_we = 1'b0;
      chk("t2_bypass_a", 64'(ex_a), 64'hA5A5_A5A5);

      // backpressure
      issue(4'd1, 1'b1, 4'd2, 1'b0, 4'd6, 1'b1, 6'h05);
      ex_ready = 1'b0;
      repeat (3) step();
      chk("t3_held_a", 64'(ex_a), 64'hA5A5_A5A5);
      ex_ready = 1'b1;
      step();
      step();

      // flush of an in-flight writer of R5
      issue(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 6'h07);
      step();
      idle();
      ex_ready = 1'b0;
      step();
      flush = 1'b1;
      step();
      chk("t4_flushed", 64'(ex_valid), 64'd0);
      flush = 1'b0;
      ex_ready = 1'b1;
      issue(4'd5, 1'b1, 4'd0, 1'b0, 4'd9, 1'b1, 6'h08);
      step();
      chk("t4_no_stall", 64'(ex_valid), 64'd1);

      // WAW on R7, same-cycle set beats writeback clear
      issue(4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 6'h01);
      step();
      step();
      step();
      wb_we = 1'b1; wb_rd = 4'd7; wb_data = 32'h0000_0777;
      step();
      wb_we = 1'b0;
      issue(4'd7, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 6'h02);
      step();
      chk("t5_still_busy", 64'(ex_valid), 64'd0);

      // saturation of the stall counter, then reset mid-stream
      repeat (40) step();
      chk("t6_saturated", 64'(stall_cnt), 64'(CNT_MAX));
      reset = 1'b1;
      step();
      chk("t6_rst_ex_valid", 64'(ex_valid), 64'd0);
      chk("t6_rst_cnt", 64'(stall_cnt), 64'd0);
      reset = 1'b0;
      step();
      chk("t6_post_reset_issue", 64'(ex_valid), 64'd1);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         dec_valid = ($urandom_range(0, 3) != 0);
         dec_rs1   = 4'($urandom_range(0, 7));
         dec_use1  = 1'($urandom);
         dec_rs2   = 4'($urandom_range(0, 7));
         dec_use2  = 1'($urandom);
         dec_rd    = 4'($urandom_range(0, 7));
         dec_wr    = 1'($urandom);
         dec_op    = 6'($urandom);
         wb_we     = 1'($urandom);
         wb_rd     = 4'($urandom_range(0, 7));
         wb_data   = $urandom;
         flush     = ($urandom_range(0, 15) == 0);
         ex_ready  = ($urandom_range(0, 3) != 0);
         reset     = ($urandom_range(0, 127) == 0);
         step();
      end
      reset = 1'b0;
      idle();
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_operand_fetch
`default_nettype wire
